// File: rtl/life_pkg.sv
// life_pkg: shared defaults and state encodings for the Game of Life core.
//   ROWS_DEF / COLS_DEF / RATE_BASE_DEF : default grid geometry and rate base
//   sweep_state_t : generation sweep FSM states
//   mode_t        : run / pause mode flag
package life_pkg;

    localparam int ROWS_DEF      = 48;
    localparam int COLS_DEF      = 64;
    localparam int RATE_BASE_DEF = 18;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } sweep_state_t;

    typedef enum logic {
        PAUSE,
        RUN
    } mode_t;

endpackage

// File: rtl/life_row_eval.sv
// life_row_eval: combinational next-generation evaluator for one grid row.
//   prev_row : row above the one being updated (0 above the top row)
//   cur_row  : row being updated
//   next_row : row below (0 below the bottom row)
//   row_out  : next-generation value of cur_row
// Columns outside 0..COLS-1 are dead; there is no wrap-around.
module life_row_eval #(
    parameter int COLS = 64
) (
    input  logic [COLS-1:0] prev_row,
    input  logic [COLS-1:0] cur_row,
    input  logic [COLS-1:0] next_row,
    output logic [COLS-1:0] row_out
);

    // One dead guard column on each side gives the edge zero-fill.
    logic [COLS+1:0] pp;
    logic [COLS+1:0] cp;
    logic [COLS+1:0] np;

    assign pp = {1'b0, prev_row, 1'b0};
    assign cp = {1'b0, cur_row,  1'b0};
    assign np = {1'b0, next_row, 1'b0};

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [3:0] n;
        // Padded index c+1 is column c; the centre cell cp[c+1] is excluded.
        assign n = 4'(pp[c]) + 4'(pp[c+1]) + 4'(pp[c+2])
                 + 4'(cp[c])               + 4'(cp[c+2])
                 + 4'(np[c]) + 4'(np[c+1]) + 4'(np[c+2]);
        assign row_out[c] = (n == 4'd3) || (cur_row[c] && (n == 4'd2));
    end

endmodule

// File: rtl/life_gen_ctrl.sv
// life_gen_ctrl: generation sequencer for the Game of Life core.
// Sweeps the grid one row per cycle through a row-wide simple dual-port RAM,
// updating rows in place behind a sliding window, and owns run/pause/step
// control plus the generation-rate prescaler.
//   sys_clk, Reset             : clock, async active-high reset
//   run_req/stop_req/step_req  : single-cycle control pulses
//   rate_sel                   : period = 2^(RATE_BASE+rate_sel) cycles
//   rd_en/rd_addr/rd_data      : RAM read port (data one cycle after rd_en)
//   wr_en/wr_addr/wr_data      : RAM write port
//   running, busy, gen_done, gen_count : status
module life_gen_ctrl
    import life_pkg::*;
#(
    parameter int ROWS      = ROWS_DEF,
    parameter int COLS      = COLS_DEF,
    parameter int RATE_BASE = RATE_BASE_DEF
) (
    input  logic                     sys_clk,
    input  logic                     Reset,
    input  logic                     run_req,
    input  logic                     stop_req,
    input  logic                     step_req,
    input  logic [2:0]               rate_sel,
    output logic                     rd_en,
    output logic [$clog2(ROWS)-1:0]  rd_addr,
    input  logic [COLS-1:0]          rd_data,
    output logic                     wr_en,
    output logic [$clog2(ROWS)-1:0]  wr_addr,
    output logic [COLS-1:0]          wr_data,
    output logic                     running,
    output logic                     busy,
    output logic                     gen_done,
    output logic [15:0]              gen_count
);

    localparam int AW = $clog2(ROWS);
    localparam int SW = $clog2(ROWS + 2);
    localparam int PW = RATE_BASE + 8;

    localparam logic [SW-1:0] S_LAST_RD = SW'(ROWS - 1);
    localparam logic [SW-1:0] S_ROWS    = SW'(ROWS);
    localparam logic [SW-1:0] S_LAST    = SW'(ROWS + 1);

    sweep_state_t    state;
    mode_t           mode;
    logic [SW-1:0]   s;
    logic [PW-1:0]   pre_cnt;
    logic [PW-1:0]   tick_mask;
    logic            tick;
    logic            start;
    logic            arrive;
    logic [COLS-1:0] prev_q;
    logic [COLS-1:0] cur_q;
    logic [COLS-1:0] next_row;
    logic [COLS-1:0] eval_row;

    // Low RATE_BASE+rate_sel bits of the free-running counter.
    assign tick_mask = ~({PW{1'b1}} << (RATE_BASE + int'(rate_sel)));
    assign tick      = (pre_cnt & tick_mask) == '0;

    assign start = (state == IDLE) &&
                   (((mode == RUN) && tick) || ((mode == PAUSE) && step_req));

    // Read data for row s-1 is on rd_data during s=1..ROWS. At s=ROWS+1 the
    // window sees a zero row below the last grid row.
    assign arrive   = (state == SWEEP) && (s != '0) && (s <= S_ROWS);
    assign next_row = arrive ? rd_data : '0;

    // prev_q/cur_q hold rows k-1/k while row k+1 is arriving, so the write of
    // row k can go out in the same cycle its lower neighbour lands. Row k
    // itself is never read again, which keeps the in-place update safe.
    life_row_eval #(.COLS(COLS)) u_eval (
        .prev_row (prev_q),
        .cur_row  (cur_q),
        .next_row (next_row),
        .row_out  (eval_row)
    );

    assign wr_data = wr_en ? eval_row : '0;
    assign running = (mode == RUN);

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            mode      <= PAUSE;
            s         <= '0;
            pre_cnt   <= '0;
            prev_q    <= '0;
            cur_q     <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            busy      <= 1'b0;
            gen_done  <= 1'b0;
            gen_count <= '0;
        end else begin
            pre_cnt  <= pre_cnt + 1'b1;
            gen_done <= 1'b0;

            if (stop_req)     mode <= PAUSE;
            else if (run_req) mode <= RUN;

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SWEEP;
                        s       <= '0;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        prev_q  <= '0;
                        cur_q   <= '0;
                    end
                end
                SWEEP: begin
                    s       <= s + 1'b1;
                    rd_en   <= (s < S_LAST_RD);
                    rd_addr <= (s < S_LAST_RD) ? AW'(s + 1'b1) : '0;
                    // Write of row k is presented at s=k+2.
                    wr_en   <= arrive;
                    wr_addr <= arrive ? AW'(s - 1'b1) : '0;
                    if (arrive) begin
                        prev_q <= cur_q;
                        cur_q  <= next_row;
                    end
                    if (s == S_LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        gen_done  <= 1'b1;
                        gen_count <= gen_count + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Scoreboard bench for life_gen_ctrl: expected row writes and gen_done
// counts are queued as stimulus is issued; a negedge monitor pops and compares.
module tb_life_gen_ctrl;

    localparam int ROWS = 48;
    localparam int COLS = 64;
    localparam int RB   = 4;

    localparam logic [63:0] BLK = 64'hC000_0000_0000_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            run_req = 1'b0, stop_req = 1'b0, step_req = 1'b0;
    logic [2:0]      rate_sel = 3'd0;
    logic            rd_en, wr_en, running, busy, gen_done;
    logic [5:0]      rd_addr, wr_addr;
    logic [COLS-1:0] rd_data, wr_data;
    logic [15:0]     gen_count;

    always #5 clk = ~clk;

    life_gen_ctrl #(.ROWS(ROWS), .COLS(COLS), .RATE_BASE(RB)) dut (
        .sys_clk(clk), .Reset(rst),
        .run_req(run_req), .stop_req(stop_req), .step_req(step_req),
        .rate_sel(rate_sel),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .running(running), .busy(busy), .gen_done(gen_done),
        .gen_count(gen_count)
    );

    // Row-wide simple dual-port RAM, registered read.
    logic [63:0] mem [ROWS];
    logic [63:0] rd_q;
    assign rd_data = rd_q;
    always @(posedge clk) begin
        if (rd_en) rd_q <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         wq[$];
    logic [15:0] dq[$];
    int          gd_t[$];
    logic [63:0] eg [ROWS];
    int          total = 0, bad = 0;
    int          cyc = 0, rd_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented write and gen_done with the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en) rd_cnt++;
            if (wr_en) begin
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_unexpected: got addr %0d data %h", wr_addr, wr_data);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk($sformatf("wr_addr_row%0d", w.addr), 64'(wr_addr), w.addr);
                    chk($sformatf("wr_data_row%0d", w.addr), wr_data, w.data);
                end
            end
            if (gen_done) begin
                gd_t.push_back(cyc);
                if (dq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL gen_done_unexpected: got count %0d", gen_count);
                end else begin
                    chk("gen_done_count", 64'(gen_count), 64'(dq.pop_front()));
                end
            end
        end
    end

    task automatic clr_mem();
        for (int k = 0; k < ROWS; k++) mem[k] = '0;
    endtask

    task automatic clr_eg();
        for (int k = 0; k < ROWS; k++) eg[k] = '0;
    endtask

    task automatic push_grid();
        for (int k = 0; k < ROWS; k++) begin
            wr_t w;
            w.addr = 64'(k);
            w.data = eg[k];
            wq.push_back(w);
        end
    endtask

    // Returns one cycle after the request was sampled (first sweep cycle s=0).
    task automatic pulse(input logic r, input logic sp, input logic st);
        @(posedge clk); #1;
        run_req = r; stop_req = sp; step_req = st;
        @(posedge clk); #1;
        run_req = 1'b0; stop_req = 1'b0; step_req = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (gd_t.size() < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 64'(gd_t.size()), 64'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int          base;
        int          r;
        int          n;
        logic [63:0] acc;

        clr_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", 64'({rd_en, wr_en, running, busy, gen_done}), 64'd0);
        chk("rst_addrs", 64'({rd_addr, wr_addr}), 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        chk("rst_gen_count", 64'(gen_count), 64'd0);
        @(negedge clk) rst = 1'b0;

        // Blinker: horizontal -> vertical -> horizontal.
        mem[10] = 64'h70;
        clr_eg(); eg[9] = 64'h20; eg[10] = 64'h20; eg[11] = 64'h20;
        push_grid(); dq.push_back(16'd1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("start_rd_en", 64'(rd_en), 64'd1);
        chk("start_rd_addr", 64'(rd_addr), 64'd0);
        chk("start_busy", 64'(busy), 64'd1);
        wait_done(1, 200, "blinker_g1_done");
        repeat (2) @(posedge clk);
        #1;
        chk("blinker_g1_row9", mem[9], 64'h20);
        chk("blinker_g1_row10", mem[10], 64'h20);
        chk("blinker_g1_row11", mem[11], 64'h20);

        clr_eg(); eg[10] = 64'h70;
        push_grid(); dq.push_back(16'd2);
        pulse(1'b0, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        pulse(1'b0, 1'b0, 1'b1);   // busy: must be ignored
        wait_done(2, 200, "blinker_g2_done");
        repeat (60) @(posedge clk);
        #1;
        chk("step_busy_one_done", 64'(gd_t.size()), 64'd2);
        chk("blinker_g2_row10", mem[10], 64'h70);
        chk("blinker_g2_row9", mem[9], 64'h0);
        chk("blinker_gen_count", 64'(gen_count), 64'd2);

        // Edge death: lone cell at row 47, column 0.
        clr_mem(); mem[47] = 64'h1;
        clr_eg(); push_grid(); dq.push_back(16'd3);
        pulse(1'b0, 1'b0, 1'b1);
        wait_done(3, 200, "edge_death_done");
        repeat (2) @(posedge clk);
        #1;
        acc = '0;
        for (int k = 0; k < ROWS; k++) acc |= mem[k];
        chk("edge_death_grid", acc, 64'd0);

        // run_req + stop_req together in IDLE: stop wins, nothing starts.
        r = rd_cnt;
        pulse(1'b1, 1'b1, 1'b0);
        chk("simul_running", 64'(running), 64'd0);
        repeat (80) @(posedge clk);
        #1;
        chk("simul_no_read", 64'(rd_cnt), 64'(r));
        chk("simul_not_busy", 64'(busy), 64'd0);

        // Block at the top-left column edge, free running, stop during sweep 5.
        clr_mem(); mem[0] = BLK; mem[1] = BLK;
        clr_eg(); eg[0] = BLK; eg[1] = BLK;
        for (int i = 0; i < 5; i++) begin
            push_grid();
            dq.push_back(16'(4 + i));
        end
        base = gd_t.size();
        pulse(1'b1, 1'b0, 1'b0);
        chk("run_running", 64'(running), 64'd1);
        wait_done(base + 4, 600, "block_4_done");
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!busy && n < 200);
        chk("block_sweep5_start", 64'(busy), 64'd1);
        repeat (20) @(posedge clk);
        #1 stop_req = 1'b1;
        @(posedge clk);
        #1 stop_req = 1'b0;
        chk("stop_running", 64'(running), 64'd0);
        chk("stop_sweep_continues", 64'(busy), 64'd1);
        wait_done(base + 5, 200, "block_5_done");
        r = rd_cnt;
        repeat (150) @(posedge clk);
        #1;
        chk("stop_no_read", 64'(rd_cnt), 64'(r));
        chk("stop_one_done", 64'(gd_t.size()), 64'(base + 5));
        chk("block_gen_count", 64'(gen_count), 64'd8);
        chk("block_row0", mem[0], BLK);
        chk("block_row1", mem[1], BLK);
        // Sweep is 51 cycles, so with a 16-cycle tick the next start is the
        // 4th tick after the previous start.
        for (int i = base + 1; i < base + 5; i++)
            chk("block_done_period", 64'(gd_t[i] - gd_t[i-1]), 64'd64);

        // Reset at s=10: rows 0..7 are written before it (all zero here).
        clr_mem(); mem[10] = 64'h70;
        for (int k = 0; k < 8; k++) begin
            wr_t w;
            w.addr = 64'(k);
            w.data = '0;
            wq.push_back(w);
        end
        pulse(1'b0, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_strobes", 64'({rd_en, wr_en, running, busy, gen_done}), 64'd0);
        chk("midrst_addrs", 64'({rd_addr, wr_addr}), 64'd0);
        chk("midrst_wr_data", wr_data, 64'd0);
        chk("midrst_gen_count", 64'(gen_count), 64'd0);
        chk("midrst_writes_seen", 64'(wq.size()), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("postrst_idle", 64'({running, busy, rd_en}), 64'd0);
        chk("postrst_gen_count", 64'(gen_count), 64'd0);

        // After reset the controller is back in PAUSE/IDLE and steps normally.
        clr_eg(); eg[9] = 64'h20; eg[10] = 64'h20; eg[11] = 64'h20;
        push_grid(); dq.push_back(16'd1);
        base = gd_t.size();
        pulse(1'b0, 1'b0, 1'b1);
        chk("postrst_start", 64'(rd_en), 64'd1);
        wait_done(base + 1, 200, "postrst_done");
        repeat (2) @(posedge clk);
        #1;
        chk("postrst_row10", mem[10], 64'h20);
        chk("final_wq_empty", 64'(wq.size()), 64'd0);
        chk("final_dq_empty", 64'(dq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
